// File: rtl/volume_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | volume_control: debounced up/down (optional mute, VOL_MUTE_EN) buttons     |
// | driving a saturating 0..MAX_LEVEL volume level with hold-to-repeat.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module volume_control #(
  parameter int MAX_LEVEL       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
`ifdef VOL_MUTE_EN
  input  logic       btn_mute,
`endif
  output logic [7:0] volume_level,
  output logic       level_changed,
  output logic       muted
);

`ifdef VOL_MUTE_EN
  localparam int NUM_BTN = 3;
`else
  localparam int NUM_BTN = 2;
`endif

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE - 1);
  localparam logic [7:0] MAX_L      = 8'(MAX_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_deb;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw[0] = btn_up;
  assign btn_raw[1] = btn_down;
`ifdef VOL_MUTE_EN
  assign btn_raw[2] = btn_mute;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [1:0] sync_q;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       db_q, db_d;
    logic       db_prev_q;

    always_comb begin
      db_cnt_d = 8'd0;
      db_d     = db_q;
      if (sync_q[1] != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_d     = sync_q[1];
          db_cnt_d = 8'd0;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= 2'b00;
        db_cnt_q  <= 8'd0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], btn_raw[i]};
        db_cnt_q  <= db_cnt_d;
        db_q      <= db_d;
        db_prev_q <= db_q;
      end
    end

    assign btn_deb[i]  = db_q;
    assign btn_rise[i] = db_q & ~db_prev_q;
  end

  state_t     state_q, state_d;
  logic       dir_up_q, dir_up_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] level_q, level_d;
  logic       muted_q, muted_d;
  logic [7:0] volume_level_q, volume_level_d;
  logic       level_changed_q, level_changed_d;

  logic step;
  logic step_up;
  logic active_held;
  logic other_held;

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    hold_cnt_d  = hold_cnt_q;
    step        = 1'b0;
    step_up     = dir_up_q;
    active_held = dir_up_q ? btn_deb[0] : btn_deb[1];
    other_held  = dir_up_q ? btn_deb[1] : btn_deb[0];

    case (state_q)
      ST_IDLE: begin
        // A rise while the other button is already down counts as "both held".
        if (btn_rise[0] && !btn_deb[1]) begin
          step       = 1'b1;
          step_up    = 1'b1;
          dir_up_d   = 1'b1;
          hold_cnt_d = DELAY_LOAD;
          state_d    = ST_HOLD_WAIT;
        end else if (btn_rise[1] && !btn_deb[0]) begin
          step       = 1'b1;
          step_up    = 1'b0;
          dir_up_d   = 1'b0;
          hold_cnt_d = DELAY_LOAD;
          state_d    = ST_HOLD_WAIT;
        end
      end
      ST_HOLD_WAIT, ST_REPEAT: begin
        if (!active_held || other_held) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == 8'd0) begin
          step       = 1'b1;
          hold_cnt_d = RATE_LOAD;
          state_d    = ST_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (step) begin
      if (step_up && (level_q < MAX_L)) begin
        level_d = level_q + 8'd1;
      end else if (!step_up && (level_q != 8'd0)) begin
        level_d = level_q - 8'd1;
      end
    end

`ifdef VOL_MUTE_EN
    muted_d = muted_q;
    if (btn_rise[2]) begin
      muted_d = ~muted_q;
    end
    if (step) begin
      muted_d = 1'b0;
    end
`else
    muted_d = 1'b0;
`endif

    volume_level_d  = muted_d ? 8'd0 : level_d;
    level_changed_d = (volume_level_d != volume_level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      dir_up_q        <= 1'b0;
      hold_cnt_q      <= 8'd0;
      level_q         <= 8'd0;
      muted_q         <= 1'b0;
      volume_level_q  <= 8'd0;
      level_changed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_up_q        <= dir_up_d;
      hold_cnt_q      <= hold_cnt_d;
      level_q         <= level_d;
      muted_q         <= muted_d;
      volume_level_q  <= volume_level_d;
      level_changed_q <= level_changed_d;
    end
  end

  assign volume_level  = volume_level_q;
  assign level_changed = level_changed_q;
  assign muted         = muted_q;

endmodule
`default_nettype wire

// File: tb/tb_volume_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_volume_control: directed bench for volume_control (default parameters). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_volume_control;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_mute;
  logic [7:0] volume_level;
  logic       level_changed;
  logic       muted;

  int checks;
  int errors;
  int lc_count;
  int lc_base;

  volume_control #(
    .MAX_LEVEL      (8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_RATE    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
`ifdef VOL_MUTE_EN
    .btn_mute     (btn_mute),
`endif
    .volume_level (volume_level),
    .level_changed(level_changed),
    .muted        (muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lc_count = 0;
  always @(negedge clk) begin
    if (level_changed === 1'b1) lc_count = lc_count + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_mute = 1'b0;

    // Reset state
    tick(3);
    chk("reset_level", {24'd0, volume_level}, 32'd0);
    chk("reset_changed", {31'd0, level_changed}, 32'd0);
    chk("reset_muted", {31'd0, muted}, 32'd0);
    rst_n = 1'b1;
    tick(50);
    chk("idle_level", {24'd0, volume_level}, 32'd0);
    chk("idle_no_pulse", lc_count, 32'd0);

    // Short glitch is filtered
    btn_up = 1'b1;
    tick(2);
    btn_up = 1'b0;
    tick(20);
    chk("glitch_level", {24'd0, volume_level}, 32'd0);
    chk("glitch_no_pulse", lc_count, 32'd0);

    // Single press: update on edge 7
    btn_up = 1'b1;
    tick(6);
    chk("press_edge6", {24'd0, volume_level}, 32'd0);
    tick(1);
    chk("press_edge7", {24'd0, volume_level}, 32'd1);
    chk("press_pulse", {31'd0, level_changed}, 32'd1);
    tick(1);
    chk("press_pulse_end", {31'd0, level_changed}, 32'd0);
    tick(2);
    btn_up = 1'b0;
    tick(30);
    chk("press_after_release", {24'd0, volume_level}, 32'd1);
    chk("press_one_pulse", lc_count, 32'd1);

    // Hold-to-repeat from 0 up to saturation
    do_reset();
    chk("rst2_level", {24'd0, volume_level}, 32'd0);
    lc_base = lc_count;
    btn_up = 1'b1;
    tick(7);
    chk("rep_edge7", {24'd0, volume_level}, 32'd1);
    tick(15);
    chk("rep_edge22", {24'd0, volume_level}, 32'd1);
    tick(1);
    chk("rep_edge23", {24'd0, volume_level}, 32'd2);
    tick(3);
    chk("rep_edge26", {24'd0, volume_level}, 32'd2);
    tick(1);
    chk("rep_edge27", {24'd0, volume_level}, 32'd3);
    tick(4);
    chk("rep_edge31", {24'd0, volume_level}, 32'd4);
    tick(15);
    chk("rep_edge46", {24'd0, volume_level}, 32'd7);
    tick(1);
    chk("rep_edge47", {24'd0, volume_level}, 32'd8);
    tick(13);
    btn_up = 1'b0;
    tick(20);
    chk("sat_level", {24'd0, volume_level}, 32'd8);
    chk("sat_pulses", lc_count - lc_base, 32'd8);

    // Down to 3, then both buttons together
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
    chk("down_to_3", {24'd0, volume_level}, 32'd3);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(30);
    chk("both_held", {24'd0, volume_level}, 32'd3);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
    chk("both_released", {24'd0, volume_level}, 32'd3);
    press(1'b0, 1'b1);
    chk("down_after_both", {24'd0, volume_level}, 32'd2);

    // Reset while in REPEAT at level 5
    btn_up = 1'b1;
    tick(7);
    chk("rr_edge7", {24'd0, volume_level}, 32'd3);
    tick(16);
    chk("rr_edge23", {24'd0, volume_level}, 32'd4);
    tick(4);
    chk("rr_edge27", {24'd0, volume_level}, 32'd5);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("rr_async_clear", {24'd0, volume_level}, 32'd0);
    chk("rr_async_pulse", {31'd0, level_changed}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rr_post_edge6", {24'd0, volume_level}, 32'd0);
    tick(1);
    chk("rr_post_edge7", {24'd0, volume_level}, 32'd1);
    btn_up = 1'b0;
    tick(20);

    // Down at 0 saturates without a pulse
    press(1'b0, 1'b1);
    chk("down_to_0", {24'd0, volume_level}, 32'd0);
    lc_base = lc_count;
    press(1'b0, 1'b1);
    chk("down_at_0", {24'd0, volume_level}, 32'd0);
    chk("down_at_0_no_pulse", lc_count - lc_base, 32'd0);

`ifdef VOL_MUTE_EN
    do_reset();
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    chk("mute_pre_level", {24'd0, volume_level}, 32'd4);
    btn_mute = 1'b1;
    tick(7);
    chk("mute_level", {24'd0, volume_level}, 32'd0);
    chk("mute_flag", {31'd0, muted}, 32'd1);
    chk("mute_pulse", {31'd0, level_changed}, 32'd1);
    btn_mute = 1'b0;
    tick(20);
    btn_up = 1'b1;
    tick(7);
    chk("unmute_flag", {31'd0, muted}, 32'd0);
    chk("unmute_level", {24'd0, volume_level}, 32'd5);
    btn_up = 1'b0;
    tick(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
